run_controller: RTL and testbench
=================================

RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter RESET_CYCLES, default 2: number of cycles CORE_RST_X is held low per run (legal 1..255).
REQ-002 Parameter HB_BITS, default 14: heartbeat period is 2^HB_BITS run cycles.
REQ-003 Parameter HALT_INSTR, default 32'h2110_4FFF: retired instruction word that terminates a run.
REQ-004 CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 RST_X  in  1  asynchronous, active-low reset.
REQ-006 START  in  1  level; requests a new run when sampled high in IDLE, DONE or TIMEOUT.
REQ-007 CS_VALID  in  1  core commit-stage valid.
REQ-008 CS_INSTR  in  32  core commit-stage instruction word.
REQ-009 CORE_RST_X  out  1  active-low reset driven to the core.
REQ-010 HEARTBEAT  out  1  one-cycle progress pulse.
REQ-011 RPT_VALID  out  1  result report valid.
REQ-012 RPT_READY  in  1  result report accepted.
REQ-013 RPT_TIMEOUT  out  1  report flag: 1 = run ended by counter exhaustion, 0 = halt.
REQ-014 RPT_CYCLES  out  32  report cycle count.

Function
REQ-015 FSM states IDLE, CORERST, RUN, DONE, TIMEOUT; exactly one active per cycle.
REQ-016 IDLE: START=1 -> CORERST; reset-cycle counter loaded with RESET_CYCLES.
REQ-017 CORERST: CORE_RST_X=0, counter decrements each cycle; after exactly RESET_CYCLES cycles in CORERST -> RUN.
REQ-018 CORE_RST_X SHALL be 1 in RUN, DONE, TIMEOUT, and 0 in IDLE and CORERST.
REQ-019 Cycle counter SHALL clear to 0 on entry to RUN and increment by 1 every RUN cycle.
REQ-020 RUN: CS_VALID=1 and CS_INSTR==HALT_INSTR -> DONE; RPT_CYCLES latches the counter value of that cycle (first RUN cycle = 0).
REQ-021 RUN: counter == 32'hFFFF_FFFF without halt -> TIMEOUT; RPT_CYCLES = 32'hFFFF_FFFF; no wrap to 0.
REQ-022 Halt and exhaustion in the same cycle: halt wins (DONE, RPT_TIMEOUT=0).
REQ-023 HALT_INSTR with CS_VALID=0 SHALL be ignored.
REQ-024 HEARTBEAT=1 for one cycle in RUN whenever counter[HB_BITS-1:0]==0 (including counter 0), else 0.
REQ-025 RPT_VALID=1 in DONE and TIMEOUT until accepted; RPT_CYCLES/RPT_TIMEOUT stable while RPT_VALID=1.
REQ-026 RPT_VALID & RPT_READY: RPT_VALID falls next cycle; state remains DONE/TIMEOUT.
REQ-027 START in DONE/TIMEOUT -> CORERST regardless of acceptance; RPT_VALID drops, report fields hold until next latch.
REQ-028 START in CORERST or RUN SHALL be ignored.

Reset
REQ-029 RST_X=0 at any time, including mid-run, SHALL force IDLE asynchronously.
REQ-030 Reset values: CORE_RST_X=0, HEARTBEAT=0, RPT_VALID=0, RPT_TIMEOUT=0, RPT_CYCLES=0, counters 0.
REQ-031 After RST_X rises, the block stays in IDLE until START is sampled high.

Structure
REQ-032 Package subrisc_pkg SHALL hold HALT_INSTR default, the state encoding, and the 32-bit count width constant.
REQ-033 Saturating 32-bit cycle counter SHALL be a sub-module run_cycle_counter (clear, enable, value, max flag).
REQ-034 Fully synthesizable; no simulation-only constructs.

Verification
REQ-035 Reset, START=1 for 1 cycle -> CORE_RST_X low exactly 2 cycles, then high; HEARTBEAT pulses on first RUN cycle.
REQ-036 Valid halt driven on RUN cycle 100 -> DONE, RPT_VALID=1, RPT_CYCLES=100, RPT_TIMEOUT=0; held until RPT_READY, then RPT_VALID=0.
REQ-037 CS_INSTR=32'h2110_4FFF with CS_VALID=0 at cycle 10, valid at cycle 20 -> RPT_CYCLES=20.
REQ-038 Counter forced near 32'hFFFF_FFFF, no halt -> TIMEOUT, RPT_TIMEOUT=1, RPT_CYCLES=32'hFFFF_FFFF; halt on max cycle -> DONE, RPT_TIMEOUT=0.
REQ-039 RST_X pulsed low during RUN -> IDLE immediately, CORE_RST_X=0, RPT_VALID=0; START in RUN -> no effect.
REQ-040 HB_BITS=4, run 40 cycles -> HEARTBEAT at counts 0, 16, 32 only.

Source files
------------

// File: rtl/subrisc_pkg.sv
// Shared constants and the FSM state encoding for the run controller.
package subrisc_pkg;

    localparam int unsigned CNT_W              = 32;
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h2110_4FFF;

    typedef enum logic [2:0] {
        StIdle,
        StCoreRst,
        StRun,
        StDone,
        StTimeout
    } state_t;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating run-cycle counter: synchronous clear has priority over enable.
module run_cycle_counter
    import subrisc_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_value,
    output logic             o_max
);

    logic [CNT_W-1:0] r_value;
    logic             w_max;

    assign w_max   = &r_value;
    assign o_value = r_value;
    assign o_max   = w_max;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value <= '0;
        end else if (i_clear) begin
            r_value <= '0;
        end else if (i_enable && !w_max) begin
            r_value <= r_value + 1'b1;
        end
    end

endmodule

// File: rtl/run_controller.sv
// Sequences core reset, times a run until halt or counter exhaustion, and
// holds a valid/ready result report.
module run_controller
    import subrisc_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned HB_BITS      = 14,
    parameter logic [31:0] HALT_INSTR   = HALT_INSTR_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             START,
    input  logic             CS_VALID,
    input  logic [31:0]      CS_INSTR,
    output logic             CORE_RST_X,
    output logic             HEARTBEAT,
    output logic             RPT_VALID,
    input  logic             RPT_READY,
    output logic             RPT_TIMEOUT,
    output logic [CNT_W-1:0] RPT_CYCLES
);

    localparam logic [7:0] RST_LOAD = 8'(RESET_CYCLES);

    state_t           r_state;
    logic [7:0]       r_rst_cnt;
    logic             r_core_rst_x;
    logic             r_rpt_valid;
    logic             r_rpt_timeout;
    logic [CNT_W-1:0] r_rpt_cycles;

    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_max;
    logic             w_halt;
    logic             w_clear;
    logic             w_enable;

    assign w_halt   = CS_VALID && (CS_INSTR == HALT_INSTR);
    // Holding clear through CORERST guarantees the first RUN cycle reads 0.
    assign w_clear  = (r_state == StCoreRst);
    assign w_enable = (r_state == StRun);

    run_cycle_counter u_cnt (
        .i_clk    (CLK),
        .i_rst_n  (RST_X),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_value  (w_cnt),
        .o_max    (w_cnt_max)
    );

    assign CORE_RST_X  = r_core_rst_x;
    assign HEARTBEAT   = (r_state == StRun) && (w_cnt[HB_BITS-1:0] == '0);
    assign RPT_VALID   = r_rpt_valid;
    assign RPT_TIMEOUT = r_rpt_timeout;
    assign RPT_CYCLES  = r_rpt_cycles;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state       <= StIdle;
            r_rst_cnt     <= '0;
            r_core_rst_x  <= 1'b0;
            r_rpt_valid   <= 1'b0;
            r_rpt_timeout <= 1'b0;
            r_rpt_cycles  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (START) begin
                        r_state   <= StCoreRst;
                        r_rst_cnt <= RST_LOAD;
                    end
                end
                StCoreRst: begin
                    if (r_rst_cnt <= 8'd1) begin
                        r_state      <= StRun;
                        r_rst_cnt    <= '0;
                        r_core_rst_x <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - 8'd1;
                    end
                end
                StRun: begin
                    // Halt outranks exhaustion when both land on the same cycle.
                    if (w_halt) begin
                        r_state       <= StDone;
                        r_rpt_valid   <= 1'b1;
                        r_rpt_timeout <= 1'b0;
                        r_rpt_cycles  <= w_cnt;
                    end else if (w_cnt_max) begin
                        r_state       <= StTimeout;
                        r_rpt_valid   <= 1'b1;
                        r_rpt_timeout <= 1'b1;
                        r_rpt_cycles  <= w_cnt;
                    end
                end
                StDone, StTimeout: begin
                    if (START) begin
                        r_state      <= StCoreRst;
                        r_rst_cnt    <= RST_LOAD;
                        r_core_rst_x <= 1'b0;
                        r_rpt_valid  <= 1'b0;
                    end else if (r_rpt_valid && RPT_READY) begin
                        r_rpt_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= StIdle;
                    r_core_rst_x <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: expected reports are queued when the
// terminating stimulus is driven and compared when RPT_VALID appears.
module tb_run_controller;

    localparam int unsigned RST_CYC = 2;
    localparam int unsigned HB_B    = 4;
    localparam logic [31:0] HALT    = 32'h2110_4FFF;

    typedef struct packed {
        logic        timeout;
        logic [31:0] cycles;
    } rpt_t;

    logic        CLK;
    logic        RST_X;
    logic        START;
    logic        CS_VALID;
    logic [31:0] CS_INSTR;
    logic        CORE_RST_X;
    logic        HEARTBEAT;
    logic        RPT_VALID;
    logic        RPT_READY;
    logic        RPT_TIMEOUT;
    logic [31:0] RPT_CYCLES;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cur      = 0;
    rpt_t exp_q[$];

    run_controller #(
        .RESET_CYCLES (RST_CYC),
        .HB_BITS      (HB_B),
        .HALT_INSTR   (HALT)
    ) dut (
        .CLK         (CLK),
        .RST_X       (RST_X),
        .START       (START),
        .CS_VALID    (CS_VALID),
        .CS_INSTR    (CS_INSTR),
        .CORE_RST_X  (CORE_RST_X),
        .HEARTBEAT   (HEARTBEAT),
        .RPT_VALID   (RPT_VALID),
        .RPT_READY   (RPT_READY),
        .RPT_TIMEOUT (RPT_TIMEOUT),
        .RPT_CYCLES  (RPT_CYCLES)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input string tag);
        int n = 0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        while (CORE_RST_X == 1'b0 && n < 50) begin
            n++;
            @(negedge CLK);
        end
        check({tag, "_corerst_len"}, n, RST_CYC);
        check({tag, "_core_rst_x_run"}, {31'd0, CORE_RST_X}, 32'd1);
        check({tag, "_hb_first"}, {31'd0, HEARTBEAT}, 32'd1);
        cur = 0;
    endtask

    task automatic advance_to(input int k);
        while (cur < k) begin
            @(negedge CLK);
            cur++;
        end
    endtask

    task automatic push_exp(input logic timeout, input logic [31:0] cycles);
        rpt_t e;
        e.timeout = timeout;
        e.cycles  = cycles;
        exp_q.push_back(e);
    endtask

    task automatic halt_at(input int k);
        advance_to(k);
        CS_VALID = 1'b1;
        CS_INSTR = HALT;
        push_exp(1'b0, k);
        @(negedge CLK);
        CS_VALID = 1'b0;
        CS_INSTR = '0;
    endtask

    task automatic wait_report(input string tag);
        int   n = 0;
        rpt_t e;
        while (!RPT_VALID && n < 100) begin
            n++;
            @(negedge CLK);
        end
        check({tag, "_valid"}, {31'd0, RPT_VALID}, 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_cycles"}, RPT_CYCLES, e.cycles);
            check({tag, "_timeout"}, {31'd0, RPT_TIMEOUT}, {31'd0, e.timeout});
        end else begin
            check({tag, "_unexpected"}, {31'd0, RPT_VALID}, 32'd0);
        end
    endtask

    task automatic accept(input string tag, input logic [31:0] cyc);
        RPT_READY = 1'b1;
        @(negedge CLK);
        RPT_READY = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, RPT_VALID}, 32'd0);
        check({tag, "_cycles_hold"}, RPT_CYCLES, cyc);
        check({tag, "_core_on"}, {31'd0, CORE_RST_X}, 32'd1);
    endtask

    task automatic force_near_max();
        force dut.u_cnt.r_value = 32'hFFFF_FFF0;
        @(negedge CLK);
        release dut.u_cnt.r_value;
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        RST_X     = 1'b0;
        START     = 1'b0;
        CS_VALID  = 1'b0;
        CS_INSTR  = '0;
        RPT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_core_rst_x", {31'd0, CORE_RST_X}, 32'd0);
        check("rst_heartbeat", {31'd0, HEARTBEAT}, 32'd0);
        check("rst_rpt_valid", {31'd0, RPT_VALID}, 32'd0);
        check("rst_rpt_timeout", {31'd0, RPT_TIMEOUT}, 32'd0);
        check("rst_rpt_cycles", RPT_CYCLES, 32'd0);
        RST_X = 1'b1;
        repeat (3) @(negedge CLK);
        check("idle_stays", {31'd0, CORE_RST_X}, 32'd0);

        // Heartbeat pattern, START ignored in RUN, then halt on cycle 100.
        start_run("run1");
        for (int c = 0; c < 40; c++) begin
            advance_to(c);
            if (c == 6) START = 1'b0;
            check($sformatf("hb_c%0d", c), {31'd0, HEARTBEAT}, (c % 16 == 0) ? 32'd1 : 32'd0);
            check($sformatf("core_c%0d", c), {31'd0, CORE_RST_X}, 32'd1);
            if (c == 5) START = 1'b1;
        end
        halt_at(100);
        wait_report("halt100");
        repeat (3) begin
            @(negedge CLK);
            check("halt100_hold_valid", {31'd0, RPT_VALID}, 32'd1);
            check("halt100_hold_cycles", RPT_CYCLES, 32'd100);
        end
        accept("halt100", 32'd100);

        // Invalid halt word and a valid non-halt word are both ignored.
        start_run("run2");
        advance_to(10);
        CS_INSTR = HALT;
        advance_to(11);
        CS_INSTR = 32'h0000_0013;
        CS_VALID = 1'b1;
        advance_to(12);
        CS_VALID = 1'b0;
        CS_INSTR = '0;
        halt_at(20);
        wait_report("halt20");
        accept("halt20", 32'd20);

        // Exhaustion without halt.
        start_run("run3");
        advance_to(3);
        push_exp(1'b1, 32'hFFFF_FFFF);
        force_near_max();
        wait_report("exhaust");
        check("exhaust_core_on", {31'd0, CORE_RST_X}, 32'd1);

        // START from TIMEOUT without acceptance; report fields hold.
        start_run("run4");
        check("restart_valid_drop", {31'd0, RPT_VALID}, 32'd0);
        check("restart_cycles_hold", RPT_CYCLES, 32'hFFFF_FFFF);
        check("restart_timeout_hold", {31'd0, RPT_TIMEOUT}, 32'd1);
        advance_to(2);
        force_near_max();
        n = 0;
        while (dut.u_cnt.o_value != 32'hFFFF_FFFF && n < 100) begin
            n++;
            @(negedge CLK);
        end
        CS_VALID = 1'b1;
        CS_INSTR = HALT;
        push_exp(1'b0, 32'hFFFF_FFFF);
        @(negedge CLK);
        CS_VALID = 1'b0;
        CS_INSTR = '0;
        wait_report("halt_at_max");
        accept("halt_at_max", 32'hFFFF_FFFF);

        // Asynchronous reset mid-run.
        start_run("run5");
        advance_to(5);
        RST_X = 1'b0;
        #1;
        check("midrst_core_rst_x", {31'd0, CORE_RST_X}, 32'd0);
        check("midrst_rpt_valid", {31'd0, RPT_VALID}, 32'd0);
        check("midrst_heartbeat", {31'd0, HEARTBEAT}, 32'd0);
        check("midrst_rpt_cycles", RPT_CYCLES, 32'd0);
        @(negedge CLK);
        RST_X = 1'b1;
        repeat (3) @(negedge CLK);
        check("midrst_idle", {31'd0, CORE_RST_X}, 32'd0);
        start_run("run6");
        halt_at(7);
        wait_report("halt7");
        accept("halt7", 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
